// File: rtl/stack_ctrl.sv
// LIFO stack sequencer: turns push/pop button levels into single requests,
// arbitrates them (pop first) and owns the pointer, storage and status flags.
module stack_ctrl #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_btn,
   input  logic              pop_btn,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              busy,
   output logic              err
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, LATCH, REJECT} state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   state_t              state;
   logic [ADDR_W-1:0]   sp;
   logic [ADDR_W-1:0]   rd_addr;
   logic                push_prev, pop_prev;
   logic                pend_push, pend_pop;
   logic                push_ev, pop_ev;
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   mem [DEPTH];

   assign push_ev = push_btn & ~push_prev;
   assign pop_ev  = pop_btn  & ~pop_prev;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (state == WRITE) mem[sp] <= data_in;
      if (state == READ)  rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sp        <= '0;
         rd_addr   <= '0;
         count     <= '0;
         data_out  <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
         push_prev <= 1'b0;
         pop_prev  <= 1'b0;
         pend_push <= 1'b0;
         pend_pop  <= 1'b0;
      end else begin
         push_prev <= push_btn;
         pop_prev  <= pop_btn;
         err       <= 1'b0;
         // A fresh event on the servicing cycle re-arms the flag.
         pend_push <= pend_push | push_ev;
         pend_pop  <= pend_pop  | pop_ev;
         case (state)
            IDLE: begin
               if (pend_pop) begin
                  pend_pop <= pop_ev;
                  busy     <= 1'b1;
                  if (empty) begin
                     state <= REJECT;
                     err   <= 1'b1;
                  end else begin
                     state   <= READ;
                     rd_addr <= sp - 1'b1;
                  end
               end else if (pend_push) begin
                  pend_push <= push_ev;
                  busy      <= 1'b1;
                  if (full) begin
                     state <= REJECT;
                     err   <= 1'b1;
                  end else begin
                     state <= WRITE;
                  end
               end
            end
            WRITE: begin
               sp    <= sp + 1'b1;
               count <= count + 1'b1;
               state <= IDLE;
               busy  <= 1'b0;
            end
            READ: begin
               state <= LATCH;
            end
            LATCH: begin
               data_out <= rd_data;
               sp       <= sp - 1'b1;
               count    <= count - 1'b1;
               state    <= IDLE;
               busy     <= 1'b0;
            end
            REJECT: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
